// File: rtl/chan_scan_mux.sv
// Registered N-channel data selector with manual select and round-robin scan.
// Scan mode holds each enabled channel for DWELL cycles before moving on.
module chan_scan_mux #(
    parameter  int WIDTH    = 12,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1000,
    localparam int SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SW-1:0]             sel,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       chan_en,
    output logic [WIDTH-1:0]          data_out,
    output logic [SW-1:0]             chan_out,
    output logic                      valid,
    output logic                      switched
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    logic [WIDTH-1:0] chans [CHANNELS];
    logic [SW-1:0]    cur_ch;
    logic [SW-1:0]    nxt_ch;
    logic [SW-1:0]    scan_ch;
    logic [SW-1:0]    probe_ch;
    logic [DW-1:0]    dwell_cnt;
    logic             dwell_done;
    mode_t            op_mode;

    assign op_mode    = mode_t'(mode);
    assign dwell_done = (dwell_cnt == DWELL_LAST);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            chans[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Walk offsets from farthest to nearest so the nearest enabled channel
    // after cur_ch wins; offset CHANNELS is cur_ch itself, the last resort.
    always_comb begin
        scan_ch  = cur_ch;
        probe_ch = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            probe_ch = SW'((int'(cur_ch) + k) % CHANNELS);
            if (chan_en[probe_ch]) begin
                scan_ch = probe_ch;
            end
        end
    end

    always_comb begin
        nxt_ch = cur_ch;
        case (op_mode)
            MANUAL: begin
                if (int'(sel) < CHANNELS) begin
                    nxt_ch = sel;
                end
            end
            SCAN: begin
                if (dwell_done) begin
                    nxt_ch = scan_ch;
                end
            end
            default: nxt_ch = cur_ch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
            data_out  <= '0;
            chan_out  <= '0;
            valid     <= 1'b0;
            switched  <= 1'b0;
        end else begin
            cur_ch   <= nxt_ch;
            chan_out <= nxt_ch;
            data_out <= chans[nxt_ch];
            valid    <= chan_en[nxt_ch];
            switched <= (nxt_ch != cur_ch);
            // Manual mode parks the counter at 0 so a later scan gets a full dwell.
            if (op_mode == MANUAL || dwell_done) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule
